// File: rtl/interval_timer_if.sv
// Signal bundle between the interval timer controller, its 4-bit counter and the
// host logic. The slave modport is the controller's view.
interface interval_timer_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic       mode;
  logic [3:0] preset;
  logic [3:0] cnt_a;
  logic       cnt_cout;
  logic       cnt_load;
  logic       cnt_count;
  logic [3:0] cnt_i;
  logic       busy;
  logic       paused;
  logic       tick;
  logic       done;
  logic [7:0] tick_cnt;

  modport master (
    output start, stop, pause, mode, preset, cnt_a, cnt_cout,
    input  cnt_load, cnt_count, cnt_i, busy, paused, tick, done, tick_cnt
  );

  modport slave (
    input  start, stop, pause, mode, preset, cnt_a, cnt_cout,
    output cnt_load, cnt_count, cnt_i, busy, paused, tick, done, tick_cnt
  );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Sequences a 4-bit loadable up-counter as a one-shot or periodic interval timer,
// with pause/stop control and a saturating count of terminal-count ticks.
module interval_timer_ctrl (
  input  logic              clk,
  input  logic              clear,
  interval_timer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSED} state_e;

  state_e     state_q, state_d;
  logic [3:0] preset_q, preset_d;
  logic       mode_q, mode_d;
  logic [7:0] tick_cnt_q, tick_cnt_d;

  logic load_c, count_c, tick_c, done_c, busy_c, paused_c;
  logic start_ok;
  logic unused_cnt_a;

  // The counter value itself is only observed by monitoring logic.
  assign unused_cnt_a = ^bus.cnt_a;
  assign start_ok     = (state_q == IDLE) && bus.start && !bus.stop;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      preset_q   <= 4'd0;
      mode_q     <= 1'b0;
      tick_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    mode_d     = mode_q;
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d    = LOAD;
          preset_d   = bus.preset;
          mode_d     = bus.mode;
          tick_cnt_d = 8'd0;
        end
      end
      LOAD: state_d = bus.stop ? IDLE : RUN;
      RUN: begin
        if (bus.stop)
          state_d = IDLE;
        else if (bus.cnt_cout)
          state_d = mode_q ? RUN : IDLE;
        else if (bus.pause)
          state_d = PAUSED;
      end
      PAUSED: begin
        if (bus.stop)
          state_d = IDLE;
        else if (!bus.pause)
          state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (tick_c && (tick_cnt_q != 8'hFF))
      tick_cnt_d = tick_cnt_q + 8'd1;
  end

  // Terminal count outranks pause, so a periodic reload never gets skipped.
  always_comb begin
    load_c   = 1'b0;
    count_c  = 1'b0;
    tick_c   = 1'b0;
    done_c   = 1'b0;
    busy_c   = 1'b0;
    paused_c = 1'b0;
    case (state_q)
      LOAD: begin
        busy_c = 1'b1;
        load_c = 1'b1;
      end
      RUN: begin
        busy_c = 1'b1;
        if (!bus.stop) begin
          if (bus.cnt_cout) begin
            tick_c = 1'b1;
            if (mode_q)
              load_c = 1'b1;
            else
              done_c = 1'b1;
          end else if (!bus.pause) begin
            count_c = 1'b1;
          end
        end
      end
      PAUSED: begin
        busy_c   = 1'b1;
        paused_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cnt_load  = load_c;
  assign bus.cnt_count = count_c;
  assign bus.cnt_i     = preset_q;
  assign bus.busy      = busy_c;
  assign bus.paused    = paused_c;
  assign bus.tick      = tick_c;
  assign bus.done      = done_c;
  assign bus.tick_cnt  = tick_cnt_q;

endmodule
